// File: rtl/inst_issue_queue.sv
// Dual-ported issue queue: up to two pushes and two pops per cycle, two oldest entries offered as candidates.
// Candidates visible one cycle after push; fetch backpressured via push_ready (needs two free slots).
module inst_issue_queue #(
   parameter int DEPTH      = 8,
   parameter int DATA_WIDTH = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    push1,
   input  logic                    push2,
   input  logic [DATA_WIDTH-1:0]   push_data1,
   input  logic [DATA_WIDTH-1:0]   push_data2,
   output logic                    push_ready,
   output logic                    cand_valid_a,
   output logic                    cand_valid_b,
   output logic [DATA_WIDTH-1:0]   cand_data_a,
   output logic [DATA_WIDTH-1:0]   cand_data_b,
   input  logic                    issue_a,
   input  logic                    issue_b,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d, rd_ptr_nxt;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d, wr_ptr_nxt;
   logic [CW-1:0]         count_q, count_d;
   logic                  push_acc, push2_acc;
   logic [1:0]            push_cnt, pop_cnt;

   // Readiness and validity come from the registered count only, so a
   // same-cycle pop never makes room for a same-cycle push.
   assign push_ready   = (count_q <= CW'(DEPTH - 2));
   assign cand_valid_a = (count_q != '0);
   assign cand_valid_b = (count_q >= CW'(2));
   assign rd_ptr_nxt   = rd_ptr_q + PW'(1);
   assign wr_ptr_nxt   = wr_ptr_q + PW'(1);
   assign cand_data_a  = mem_q[rd_ptr_q];
   assign cand_data_b  = mem_q[rd_ptr_nxt];
   assign count        = count_q;

   always_comb begin
      push_acc  = push1 & push_ready & ~flush;
      push2_acc = push_acc & push2;
      push_cnt  = {1'b0, push_acc} + {1'b0, push2_acc};
      pop_cnt   = {1'b0, issue_a & cand_valid_a}
                + {1'b0, issue_a & issue_b & cand_valid_b};
      rd_ptr_d  = rd_ptr_q + PW'(pop_cnt);
      wr_ptr_d  = wr_ptr_q + PW'(push_cnt);
      count_d   = count_q + CW'(push_cnt) - CW'(pop_cnt);
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage is never cleared; validity is tracked by count alone.
   always_ff @(posedge clk) begin
      if (push_acc)  mem_q[wr_ptr_q]   <= push_data1;
      if (push2_acc) mem_q[wr_ptr_nxt] <= push_data2;
   end

endmodule

// File: tb/tb_inst_issue_queue.sv
// Self-checking bench for inst_issue_queue: directed vector table, hand sequences, random run vs queue model.
module tb_inst_issue_queue;

   localparam int DEPTH = 8;
   localparam int DW    = 64;

   logic          clk = 1'b0;
   logic          rst, flush, push1, push2, issue_a, issue_b;
   logic [DW-1:0] push_data1, push_data2;
   logic          push_ready, cand_valid_a, cand_valid_b;
   logic [DW-1:0] cand_data_a, cand_data_b;
   logic [$clog2(DEPTH):0] count;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [DW-1:0] mq[$];

   always #5 clk = ~clk;

   inst_issue_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .push1(push1), .push2(push2),
      .push_data1(push_data1), .push_data2(push_data2),
      .push_ready(push_ready),
      .cand_valid_a(cand_valid_a), .cand_valid_b(cand_valid_b),
      .cand_data_a(cand_data_a), .cand_data_b(cand_data_b),
      .issue_a(issue_a), .issue_b(issue_b),
      .count(count)
   );

   typedef struct {
      logic          fl, p1, p2;
      logic [DW-1:0] d1, d2;
      logic          ia, ib;
      int            ecnt;
      logic          eva, evb, erdy;
      logic [DW-1:0] ea, eb;
   } vec_t;

   vec_t vecs[17];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      int sz;
      sz = mq.size();
      chk("m_count", DW'(count), DW'(sz));
      chk("m_valid_a", DW'(cand_valid_a), DW'(sz >= 1));
      chk("m_valid_b", DW'(cand_valid_b), DW'(sz >= 2));
      chk("m_ready", DW'(push_ready), DW'(sz <= DEPTH - 2));
      if (sz >= 1) chk("m_cand_a", cand_data_a, mq[0]);
      if (sz >= 2) chk("m_cand_b", cand_data_b, mq[1]);
   endtask

   // Drives one cycle of inputs, advances the model by the queue rules, checks after the edge.
   task automatic cycle(input logic r, input logic fl, input logic p1, input logic p2,
                        input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                        input logic ia, input logic ib);
      bit rdy_m;
      int np;
      rst = r; flush = fl; push1 = p1; push2 = p2;
      push_data1 = d1; push_data2 = d2; issue_a = ia; issue_b = ib;
      rdy_m = (mq.size() <= DEPTH - 2);
      np = 0;
      if (ia && mq.size() >= 1) np++;
      if (ia && ib && mq.size() >= 2) np++;
      @(posedge clk);
      #1;
      if (r || fl) begin
         mq.delete();
      end else begin
         for (int k = 0; k < np; k++) void'(mq.pop_front());
         if (p1 && rdy_m) begin
            mq.push_back(d1);
            if (p2) mq.push_back(d2);
         end
      end
      check_model();
   endtask

   initial begin
      // fl p1 p2 d1 d2 ia ib | cnt va vb rdy a b
      vecs[0]  = '{0,1,1,64'h10,64'h11,0,0, 2,1,1,1,64'h10,64'h11};
      vecs[1]  = '{0,1,0,64'h12,64'h0, 0,0, 3,1,1,1,64'h10,64'h11};
      vecs[2]  = '{0,0,0,64'h0, 64'h0, 1,0, 2,1,1,1,64'h11,64'h12};
      vecs[3]  = '{0,0,0,64'h0, 64'h0, 1,1, 0,0,0,1,64'h0, 64'h0};
      vecs[4]  = '{0,0,1,64'h0, 64'h99,0,0, 0,0,0,1,64'h0, 64'h0};
      vecs[5]  = '{0,1,0,64'h20,64'h0, 0,0, 1,1,0,1,64'h20,64'h0};
      vecs[6]  = '{0,0,0,64'h0, 64'h0, 0,1, 1,1,0,1,64'h20,64'h0};
      vecs[7]  = '{0,0,0,64'h0, 64'h0, 1,1, 0,0,0,1,64'h0, 64'h0};
      vecs[8]  = '{0,1,1,64'h30,64'h31,0,0, 2,1,1,1,64'h30,64'h31};
      vecs[9]  = '{0,1,1,64'h32,64'h33,0,0, 4,1,1,1,64'h30,64'h31};
      vecs[10] = '{1,1,1,64'h40,64'h41,1,1, 0,0,0,1,64'h0, 64'h0};
      vecs[11] = '{0,1,1,64'h50,64'h51,0,0, 2,1,1,1,64'h50,64'h51};
      vecs[12] = '{0,1,1,64'h52,64'h53,0,0, 4,1,1,1,64'h50,64'h51};
      vecs[13] = '{0,1,1,64'h54,64'h55,0,0, 6,1,1,1,64'h50,64'h51};
      vecs[14] = '{0,1,0,64'h56,64'h0, 0,0, 7,1,1,0,64'h50,64'h51};
      vecs[15] = '{0,1,1,64'h57,64'h58,1,1, 5,1,1,1,64'h52,64'h53};
      vecs[16] = '{0,1,1,64'h60,64'h61,1,0, 6,1,1,1,64'h53,64'h54};

      rst = 1'b1; flush = 1'b0; push1 = 1'b0; push2 = 1'b0;
      push_data1 = '0; push_data2 = '0; issue_a = 1'b0; issue_b = 1'b0;

      // Reset state
      cycle(1, 0, 0, 0, 0, 0, 0, 0);
      cycle(1, 0, 1, 1, 64'hAA, 64'hBB, 0, 0);
      chk("rst_count", DW'(count), 0);
      chk("rst_valid_a", DW'(cand_valid_a), 0);
      chk("rst_valid_b", DW'(cand_valid_b), 0);
      chk("rst_ready", DW'(push_ready), 1);

      // Directed vector table
      for (int i = 0; i < 17; i++) begin
         cycle(0, vecs[i].fl, vecs[i].p1, vecs[i].p2, vecs[i].d1, vecs[i].d2, vecs[i].ia, vecs[i].ib);
         chk($sformatf("v%0d_count", i), DW'(count), DW'(vecs[i].ecnt));
         chk($sformatf("v%0d_valid_a", i), DW'(cand_valid_a), DW'(vecs[i].eva));
         chk($sformatf("v%0d_valid_b", i), DW'(cand_valid_b), DW'(vecs[i].evb));
         chk($sformatf("v%0d_ready", i), DW'(push_ready), DW'(vecs[i].erdy));
         if (vecs[i].eva) chk($sformatf("v%0d_cand_a", i), cand_data_a, vecs[i].ea);
         if (vecs[i].evb) chk($sformatf("v%0d_cand_b", i), cand_data_b, vecs[i].eb);
      end

      // Mid-run reset with activity discards everything
      cycle(1, 0, 1, 1, 64'h70, 64'h71, 1, 1);
      chk("rst2_count", DW'(count), 0);
      chk("rst2_ready", DW'(push_ready), 1);

      // Streaming two in / two out across pointer wrap
      cycle(0, 0, 1, 1, 64'h100, 64'h101, 0, 0);
      for (int i = 0; i < 3 * DEPTH; i++) begin
         cycle(0, 0, 1, 1, 64'h102 + 2 * i, 64'h103 + 2 * i, 1, 1);
         chk("stream_count", DW'(count), 2);
         chk("stream_cand_a", cand_data_a, 64'h102 + 2 * i);
         chk("stream_cand_b", cand_data_b, 64'h103 + 2 * i);
      end
      cycle(0, 1, 0, 0, 0, 0, 0, 0);
      chk("stream_flush_count", DW'(count), 0);

      // Randomized run against the queue model
      for (int i = 0; i < 3000; i++) begin
         logic r, fl, p1, p2, ia, ib;
         r  = ($urandom_range(0, 99) == 0);
         fl = ($urandom_range(0, 39) == 0);
         p1 = ($urandom_range(0, 99) < 65);
         p2 = ($urandom_range(0, 99) < 60);
         ia = ($urandom_range(0, 99) < 55);
         ib = ($urandom_range(0, 99) < 50);
         cycle(r, fl, p1, p2, {$urandom, $urandom}, {$urandom, $urandom}, ia, ib);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_issue_queue.md
# inst_issue_queue

Dual-ported instruction queue between the fetch stage and the dual-issue decode stage. It accepts up to two fetched instructions per cycle and presents the two oldest as the pipe-a and pipe-b candidates. It retires one or two entries per cycle according to the superscalar issue decision, so that an instruction not issued to pipe-b becomes the pipe-a candidate on the next cycle. Flush support discards all queued instructions on branch redirect or exception.

## Interface
Parameters:
- DEPTH, 8: entry count; power of two, at least 4.
- DATA_WIDTH, 64: entry payload width (PC plus instruction word).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all entries; wins over push and pop in the same cycle.
- push1  in  1  enqueue push_data1 (older fetched instruction).
- push2  in  1  enqueue push_data2 (younger); honoured only together with push1.
- push_data1  in  DATA_WIDTH  older fetched entry.
- push_data2  in  DATA_WIDTH  younger fetched entry.
- push_ready  out  1  at least two free entries; combinational from the registered count.
- cand_valid_a  out  1  pipe-a candidate valid (count ≥ 1).
- cand_valid_b  out  1  pipe-b candidate valid (count ≥ 2).
- cand_data_a  out  DATA_WIDTH  oldest entry.
- cand_data_b  out  DATA_WIDTH  second-oldest entry.
- issue_a  in  1  pipe-a candidate consumed this cycle.
- issue_b  in  1  pipe-b candidate consumed; driven from the decode's inst2_taken.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Storage: circular buffer with rd_ptr, wr_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH), and count.
- Candidates: cand_data_a = mem[rd_ptr]; cand_data_b = mem[rd_ptr+1 mod DEPTH]. Both are read combinationally from registered storage. There is no push-to-output bypass.
- Push acceptance: push_acc = push1 & push_ready & ~flush. The write count is 1 + (push2 & push_acc). push_data1 is written at wr_ptr and push_data2 at wr_ptr+1. When push_ready = 0, the push is dropped; fetch holds and retries. push2 without push1 is ignored entirely.
- Pop count: pop = (issue_a & cand_valid_a) + (issue_a & issue_b & cand_valid_b). issue_b without issue_a pops nothing. The pop count never exceeds count.
- Update: rd_ptr += pop; wr_ptr += pushed; count = count + pushed − pop, all in one cycle. Simultaneous push and pop is legal at any occupancy.
- push_ready uses the pre-update count. A pop in the same cycle does not free space for that cycle's push, so DEPTH−1 occupancy with pop=2 still rejects.
- Flush: next cycle, rd_ptr = wr_ptr = count = 0. Storage contents are not cleared and are don't-care. Same-cycle push and pop are discarded.
- Reset: identical to flush. After reset: count=0, cand_valid_a=0, cand_valid_b=0, push_ready=1. The cand_data outputs are don't-care while invalid.
- Invariant: 0 ≤ count ≤ DEPTH at all times; count never exceeds DEPTH given push_ready gating.

## Timing
- Push latency: an entry pushed in cycle N is visible as a candidate in cycle N+1 at the earliest.
- Pop effect: issue in cycle N advances the candidates in cycle N+1. With issue_a=1 and issue_b=0, the old cand_b becomes cand_a.
- All outputs change only after the rising edge, except cand_data and push_ready, which are combinational from registers (no input-to-output paths).
- rst or flush asserted in cycle N yields an empty queue in N+1, regardless of any activity in N.

## Test plan
- Reset, then push1=push2=1 with data 0x10/0x11 -> next cycle count=2, cand_a=0x10, cand_b=0x11, both valid.
- With entries 0x10,0x11,0x12: issue_a=1, issue_b=0 -> cand_a=0x11, cand_b=0x12, count=2. Then issue_a=issue_b=1 -> count=0, cand_valid_a=0.
- Fill to DEPTH−1 (7): push_ready=0. Push with pop=2 in the same cycle -> push dropped, count=5. Next cycle push_ready=1.
- Push/pop 2 per cycle for 3×DEPTH cycles with incrementing data -> candidates strictly in order across pointer wrap, count constant at 2.
- flush=1 with push1=push2=1 and issue_a=issue_b=1 at count=4 -> next cycle count=0, push_ready=1, no new entries.
- Illegal stimulus: push2 alone -> no entry. issue_b alone -> no pop. issue_a=issue_b=1 at count=1 -> count=0, never underflows.
